mmul2_sequencer: RTL and testbench

Index sequencer for the 2-D matrix-multiply datapath. On a start pulse it walks the triple loop i (rows of A), j (columns of B), k (inner dimension) in row-major order and presents one (i, j, k) tuple per accepted cycle. It also emits accumulator-control flags and a completion pulse. It sits directly upstream of the MAC datapath and of mmul2_arbiter, and drives their i/j/k inputs.

---
 rtl/mmul2_pkg.sv | 16 +
 rtl/mmul2_idx_counter.sv | 26 ++
 rtl/mmul2_sequencer.sv | 96 +++++++++
 tb/tb_mmul2_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mmul2_pkg.sv
// Shared constants for the 2-D matrix-multiply index sequencer.
package mmul2_pkg;

  localparam int IDX_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/mmul2_idx_counter.sv
// One wrapping loop index; wrap fires combinationally on the advancing cycle at LIMIT-1.
module mmul2_idx_counter
  import mmul2_pkg::*;
#(
  parameter int unsigned LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LIMIT - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (wrap) cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mmul2_sequencer.sv
// Walks (i, j, k) over RA x CB x RB in row-major order, one tuple per accepted cycle,
// with accumulator flags and a one-cycle completion pulse.
module mmul2_sequencer
  import mmul2_pkg::*;
#(
  parameter int unsigned RA = 2,
  parameter int unsigned CA = 2,
  parameter int unsigned RB = 2,
  parameter int unsigned CB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             valid,
  output logic             k_first,
  output logic             k_last,
  output logic             busy,
  output logic             done
);

  if (RA < 1 || RB < 1 || CB < 1 || CA != RB) begin : g_bad_dims
    $fatal(1, "mmul2_sequencer: need RA, RB, CB >= 1 and CA == RB");
  end

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(RB - 1);

  state_t state;
  logic   accept, clr;
  logic   k_wrap, j_wrap, i_wrap;

  // Abort overrides stall and also blocks the advance so the clear is clean.
  assign accept = valid && !stall && !abort;
  assign clr    = (state != S_RUN) || abort;

  mmul2_idx_counter #(.LIMIT(RB)) u_k (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(accept), .cnt(k), .wrap(k_wrap)
  );
  mmul2_idx_counter #(.LIMIT(CB)) u_j (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(k_wrap), .cnt(j), .wrap(j_wrap)
  );
  mmul2_idx_counter #(.LIMIT(RA)) u_i (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(j_wrap), .cnt(i), .wrap(i_wrap)
  );

  assign k_first = valid && (k == '0);
  assign k_last  = valid && (k == K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_RUN;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (i_wrap) begin
            // Final tuple accepted; every counter has wrapped back to 0.
            state <= S_DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmul2_sequencer.sv
// Directed bench: three sequencer instances (2x2x2, 3x4x2, 1x1x1) driven by one linear script.
module tb_mmul2_sequencer;

  logic clk = 1'b0;
  logic rst_n, abort, stall, start_a, start_b, start_c;

  logic [31:0] ia, ja, ka, ib, jb, kb, ic, jc, kc;
  logic va, kfa, kla, ba, da;
  logic vb, kfb, klb, bb, db;
  logic vc, kfc, klc, bc, dc;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mmul2_sequencer #(.RA(2), .CA(2), .RB(2), .CB(2)) ua (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .stall(stall),
    .i(ia), .j(ja), .k(ka), .valid(va), .k_first(kfa), .k_last(kla), .busy(ba), .done(da)
  );
  mmul2_sequencer #(.RA(3), .CA(4), .RB(4), .CB(2)) ub (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .stall(stall),
    .i(ib), .j(jb), .k(kb), .valid(vb), .k_first(kfb), .k_last(klb), .busy(bb), .done(db)
  );
  mmul2_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1)) uc (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .stall(stall),
    .i(ic), .j(jc), .k(kc), .valid(vc), .k_first(kfc), .k_last(klc), .busy(bc), .done(dc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic chkt(input string tag, input logic [31:0] oi, input logic [31:0] oj,
                      input logic [31:0] ok, input int ei, input int ej, input int ek);
    total++;
    assert ({oi, oj, ok} === {32'(ei), 32'(ej), 32'(ek)}) passes++;
    else $error("FAIL %s: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", tag, oi, oj, ok, ei, ej, ek);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  int vcount, klcount;

  initial begin
    rst_n = 1'b0; abort = 1'b0; stall = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", va, 1'b0);
    chk1("rst_busy", ba, 1'b0);
    chk1("rst_done", da, 1'b0);
    chk1("rst_kfirst", kfa, 1'b0);
    chk1("rst_klast", kla, 1'b0);
    chkt("rst_tuple", ia, ja, ka, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // Reset mid-run after three tuples.
    start_a = 1'b1; step(); start_a = 1'b0;
    chk1("mr_valid0", va, 1'b1);
    chk1("mr_busy0", ba, 1'b1);
    chkt("mr_t0", ia, ja, ka, 0, 0, 0);
    step(); chkt("mr_t1", ia, ja, ka, 0, 0, 1);
    step(); chkt("mr_t2", ia, ja, ka, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk1("mr_async_valid", va, 1'b0);
    chk1("mr_async_busy", ba, 1'b0);
    chk1("mr_async_done", da, 1'b0);
    chkt("mr_async_tuple", ia, ja, ka, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk1("mr_post_done", da, 1'b0);
    chk1("mr_post_valid", va, 1'b0);

    // Full 2x2x2 sweep, no stall.
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chk1("sw_valid", va, 1'b1);
      chkt("sw_tuple", ia, ja, ka, t / 4, (t / 2) % 2, t % 2);
      chk1("sw_kfirst", kfa, (t % 2) == 0);
      chk1("sw_klast", kla, (t % 2) == 1);
      chk1("sw_nodone", da, 1'b0);
      step();
    end
    chk1("sw_done", da, 1'b1);
    chk1("sw_done_valid", va, 1'b0);
    chk1("sw_done_busy", ba, 1'b1);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk1("sw_done_pulse", da, 1'b0);
    chk1("sw_idle_busy", ba, 1'b0);
    chk1("sw_start_in_done_ignored", va, 1'b0);
    step();

    // Stall for 3 cycles at tuple (0,1,1).
    vcount = 0;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chkt("st_tuple", ia, ja, ka, t / 4, (t / 2) % 2, t % 2);
      if (va) vcount++;
      if (t == 3) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          chkt("st_hold", ia, ja, ka, 0, 1, 1);
          chk1("st_hold_klast", kla, 1'b1);
          if (va) vcount++;
        end
        stall = 1'b0;
      end
      step();
    end
    chk1("st_done", da, 1'b1);
    chkn("st_valid_cycles", vcount, 11);
    step(); step();

    // Abort with stall at (1,0,1); start mid-run ignored.
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int t = 0; t < 5; t++) begin
      chkt("ab_tuple", ia, ja, ka, t / 4, (t / 2) % 2, t % 2);
      start_a = (t == 2);
      step();
    end
    start_a = 1'b0;
    chkt("ab_at", ia, ja, ka, 1, 0, 1);
    abort = 1'b1; stall = 1'b1;
    step();
    abort = 1'b0; stall = 1'b0;
    chk1("ab_valid", va, 1'b0);
    chk1("ab_busy", ba, 1'b0);
    chk1("ab_done", da, 1'b0);
    chkt("ab_clear", ia, ja, ka, 0, 0, 0);
    step();
    chk1("ab_done_later", da, 1'b0);

    // Non-square 3x4 by 4x2.
    klcount = 0;
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int t = 0; t < 24; t++) begin
      chkt("ns_tuple", ib, jb, kb, t / 8, (t / 4) % 2, t % 4);
      chk1("ns_valid", vb, 1'b1);
      if (klb) klcount++;
      step();
    end
    chk1("ns_done", db, 1'b1);
    chk1("ns_valid_end", vb, 1'b0);
    chkn("ns_klast_count", klcount, 6);
    step();

    // Degenerate 1x1x1 and back-to-back start.
    start_c = 1'b1; step(); start_c = 1'b0;
    chk1("dg_valid", vc, 1'b1);
    chkt("dg_tuple", ic, jc, kc, 0, 0, 0);
    chk1("dg_kfirst", kfc, 1'b1);
    chk1("dg_klast", klc, 1'b1);
    step();
    chk1("dg_done", dc, 1'b1);
    chk1("dg_done_valid", vc, 1'b0);
    step();
    chk1("dg_idle_done", dc, 1'b0);
    start_c = 1'b1; step(); start_c = 1'b0;
    chk1("dg_b2b_valid", vc, 1'b1);
    chkt("dg_b2b_tuple", ic, jc, kc, 0, 0, 0);
    step();
    chk1("dg_b2b_done", dc, 1'b1);
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
